// File: rtl/led_sequencer_if.sv
// Configuration register bus for led_sequencer: write/read strobes, address,
// write data and the registered read-back pair.
interface led_sequencer_if;
    logic       cfg_we;
    logic       cfg_re;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       cfg_rvalid;

    modport master (
        output cfg_we, cfg_re, cfg_addr, cfg_wdata,
        input  cfg_rdata, cfg_rvalid
    );

    modport slave (
        input  cfg_we, cfg_re, cfg_addr, cfg_wdata,
        output cfg_rdata, cfg_rvalid
    );
endinterface

// File: rtl/led_sequencer.sv
// Register-programmed red/green LED blink sequencer with phase-boundary mode changes.
// Define LED_PWM_EN to build the optional DUTY-controlled PWM dimming of lit LEDs.
module led_sequencer #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic           xclk,
    input  logic           rst,
    led_sequencer_if.slave cfg,
    output logic           led_r,
    output logic           led_g,
    output logic           done
);
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ALT   = 2'd1,
        MODE_SYNC  = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    mode_e       mode_q, mode_d, pend_q, pend_d, wmode;
    logic        pend_v_q, pend_v_d;
    logic [7:0]  half_q, half_d, half_act_q, half_act_d;
    logic [7:0]  burst_q, burst_d, bcnt_q, bcnt_d, tcnt_q, tcnt_d;
    logic [7:0]  rdata_q, rdata_d, half_eff;
    logic [15:0] presc_q, presc_d;
    logic        phase_q, phase_d, fin_q, fin_d, rvalid_q, rvalid_d;
    logic        led_r_q, led_r_d, led_g_q, led_g_d, done_q, done_d;
    logic        tick, boundary, pat_r, pat_g, pwm_on;
    logic [1:0]  mode_rd;
`ifdef LED_PWM_EN
    logic [7:0]  duty_q, duty_d;
    logic [3:0]  pwm_q, pwm_d;
`endif

    always_comb begin
        half_eff   = (half_act_q == 8'd0) ? 8'd1 : half_act_q;
        tick       = (mode_q != MODE_OFF) && (presc_q == PRESC_MAX);
        boundary   = tick && (tcnt_q == half_eff - 8'd1);
        wmode      = mode_e'(cfg.cfg_wdata[1:0]);

        mode_d     = mode_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        half_d     = half_q;
        half_act_d = half_act_q;
        burst_d    = burst_q;
        bcnt_d     = bcnt_q;
        tcnt_d     = tcnt_q;
        presc_d    = presc_q;
        phase_d    = phase_q;
        fin_d      = 1'b0;
`ifdef LED_PWM_EN
        duty_d     = duty_q;
        pwm_d      = pwm_q + 4'd1;
`endif

        if (mode_q != MODE_OFF) begin
            presc_d = tick ? '0 : presc_q + 16'd1;
            if (tick) begin
                tcnt_d = boundary ? '0 : tcnt_q + 8'd1;
            end
            if (boundary) begin
                phase_d    = ~phase_q;
                half_act_d = half_q;
                if (pend_v_q) begin
                    mode_d   = pend_q;
                    pend_v_d = 1'b0;
                    phase_d  = 1'b0;
                    bcnt_d   = '0;
                end else if (mode_q == MODE_BURST && phase_q) begin
                    if (bcnt_q + 8'd1 >= burst_q) begin
                        mode_d  = MODE_OFF;
                        phase_d = 1'b0;
                        bcnt_d  = '0;
                        fin_d   = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 8'd1;
                    end
                end
            end
        end

        // Decisions use mode_d so a write landing on a burst-end boundary starts cleanly from OFF
        if (cfg.cfg_we) begin
            case (cfg.cfg_addr)
                2'd0: begin
                    if (wmode == MODE_OFF || mode_d == MODE_OFF) begin
                        mode_d     = wmode;
                        pend_v_d   = 1'b0;
                        presc_d    = '0;
                        tcnt_d     = '0;
                        phase_d    = 1'b0;
                        bcnt_d     = '0;
                        half_act_d = half_q;
                    end else if (wmode != mode_d) begin
                        pend_d   = wmode;
                        pend_v_d = 1'b1;
                    end
                end
                2'd1: half_d  = cfg.cfg_wdata;
                2'd2: burst_d = cfg.cfg_wdata;
                default: begin
`ifdef LED_PWM_EN
                    duty_d = cfg.cfg_wdata;
`endif
                end
            endcase
        end

        pat_r = 1'b0;
        pat_g = 1'b0;
        case (mode_q)
            MODE_ALT: begin
                pat_r = ~phase_q;
                pat_g = phase_q;
            end
            MODE_SYNC: begin
                pat_r = ~phase_q;
                pat_g = ~phase_q;
            end
            MODE_BURST: begin
                pat_r = ~phase_q && (burst_q != 8'd0);
                pat_g = pat_r;
            end
            default: ;
        endcase

`ifdef LED_PWM_EN
        pwm_on = (pwm_q <= duty_q[3:0]);
`else
        pwm_on = 1'b1;
`endif
        led_r_d  = pat_r & pwm_on;
        led_g_d  = pat_g & pwm_on;
        done_d   = fin_q;

        mode_rd  = pend_v_d ? pend_d : mode_d;
        rvalid_d = cfg.cfg_re;
        rdata_d  = rdata_q;
        if (cfg.cfg_re) begin
            case (cfg.cfg_addr)
                2'd0:    rdata_d = {6'd0, mode_rd};
                2'd1:    rdata_d = half_d;
                2'd2:    rdata_d = burst_d;
`ifdef LED_PWM_EN
                default: rdata_d = duty_d;
`else
                default: rdata_d = 8'd0;
`endif
            endcase
        end
    end

    always_ff @(posedge xclk) begin
        if (rst) begin
            mode_q     <= MODE_OFF;
            pend_q     <= MODE_OFF;
            pend_v_q   <= 1'b0;
            half_q     <= 8'd50;
            half_act_q <= 8'd50;
            burst_q    <= 8'd3;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
            presc_q    <= '0;
            phase_q    <= 1'b0;
            fin_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            led_r_q    <= 1'b0;
            led_g_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef LED_PWM_EN
            duty_q     <= 8'd15;
            pwm_q      <= '0;
`endif
        end else begin
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            half_q     <= half_d;
            half_act_q <= half_act_d;
            burst_q    <= burst_d;
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
            presc_q    <= presc_d;
            phase_q    <= phase_d;
            fin_q      <= fin_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            led_r_q    <= led_r_d;
            led_g_q    <= led_g_d;
            done_q     <= done_d;
`ifdef LED_PWM_EN
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
`endif
        end
    end

    assign led_r          = led_r_q;
    assign led_g          = led_g_q;
    assign done           = done_q;
    assign cfg.cfg_rdata  = rdata_q;
    assign cfg.cfg_rvalid = rvalid_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: stimulus queues expected LED/done and read-back
// values computed from blink-timing arithmetic; a negedge monitor pops and compares.
module tb_led_sequencer;
    localparam int TD = 4;
`ifdef LED_PWM_EN
    localparam int DUTY_RST = 15;
`else
    localparam int DUTY_RST = 0;
`endif

    logic xclk = 1'b0;
    logic rst  = 1'b1;
    logic led_r, led_g, done;

    led_sequencer_if bus();

    led_sequencer #(.TICK_DIV(TD)) dut (
        .xclk  (xclk),
        .rst   (rst),
        .cfg   (bus),
        .led_r (led_r),
        .led_g (led_g),
        .done  (done)
    );

    always #5 xclk = ~xclk;

    typedef struct packed {
        logic r;
        logic g;
        logic d;
    } led_t;

    led_t       led_q[$];
    logic [7:0] rd_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs t cycles after the MODE write edge, starting from OFF.
    function automatic led_t exp_led(input int m, input int h, input int b, input int t);
        led_t e;
        int   len, p, bend;
        e   = '0;
        len = ((h == 0) ? 1 : h) * TD;
        if (t == 0) return e;
        p = (t - 1) / len;
        case (m)
            1: begin
                e.r = (p % 2 == 0);
                e.g = (p % 2 == 1);
            end
            2: begin
                e.r = (p % 2 == 0);
                e.g = e.r;
            end
            3: begin
                bend = (b == 0) ? 1 : b;
                if (t > 2 * bend * len) begin
                    e.d = (t == 2 * bend * len + 1);
                end else begin
                    e.r = (p % 2 == 0) && (b != 0);
                    e.g = e.r;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge xclk) begin : monitor
        led_t       e;
        logic [7:0] x;
        if (bus.cfg_rvalid) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got rvalid with rdata %0d, expected no read", bus.cfg_rdata);
            end else begin
                x = rd_q.pop_front();
                check("rdata", int'(bus.cfg_rdata), int'(x));
            end
        end
        if (led_q.size() != 0) begin
            e = led_q.pop_front();
            check("led_r", int'(led_r), int'(e.r));
            check("led_g", int'(led_g), int'(e.g));
            check("done",  int'(done),  int'(e.d));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        @(posedge xclk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        bus.cfg_re   = 1'b1;
        bus.cfg_addr = a;
        @(posedge xclk);
        #1;
        bus.cfg_re = 1'b0;
    endtask

    task automatic wrrd(input logic [1:0] a, input logic [7:0] d, input logic [7:0] exp);
        rd_q.push_back(exp);
        bus.cfg_we    = 1'b1;
        bus.cfg_re    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        @(posedge xclk);
        #1;
        bus.cfg_we = 1'b0;
        bus.cfg_re = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((led_q.size() != 0 || rd_q.size() != 0) && n < 2000) begin
            @(posedge xclk);
            n++;
        end
        #1;
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL drain: %0d led and %0d read items left, expected 0", led_q.size(), rd_q.size());
            led_q.delete();
            rd_q.delete();
        end
    endtask

    task automatic go_off();
        wr(2'd0, 8'd0);
        @(posedge xclk);
        #1;
        repeat (3) led_q.push_back(led_t'(3'b000));
        drain();
    endtask

    task automatic run_scn(input int m, input int h, input int b);
        int len, n;
        len = ((h == 0) ? 1 : h) * TD;
        wr(2'd1, 8'(h));
        wr(2'd2, 8'(b));
        wr(2'd0, 8'(m));
        n = (m == 3) ? 2 * ((b == 0) ? 1 : b) * len + 4 : 4 * len + 2;
        for (int t = 0; t < n; t++) led_q.push_back(exp_led(m, h, b, t));
        drain();
        rd(2'd0, (m == 3) ? 8'd0 : 8'(m));
        drain();
        go_off();
    endtask

    task automatic read_resets();
        rd(2'd0, 8'd0);
        rd(2'd1, 8'd50);
        rd(2'd2, 8'd3);
        rd(2'd3, 8'(DUTY_RST));
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_re    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = 8'd0;
        repeat (3) @(posedge xclk);
        #1;
        rst = 1'b0;
        check("reset_led_r",  int'(led_r), 0);
        check("reset_led_g",  int'(led_g), 0);
        check("reset_done",   int'(done), 0);
        check("reset_rvalid", int'(bus.cfg_rvalid), 0);
        check("reset_rdata",  int'(bus.cfg_rdata), 0);
        read_resets();

        // Boundary cases first: HALF=0, BURST=0, then the documented burst and ALT cases.
        run_scn(3, 0, 0);
        run_scn(3, 1, 2);
        run_scn(1, 2, 0);
        for (int i = 0; i < 5; i++)
            run_scn(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

        // SYNC running, switch to ALT mid-phase with a simultaneous read-back
        wr(2'd1, 8'd2);
        wr(2'd0, 8'd2);
        for (int t = 0; t <= 8; t++) led_q.push_back(exp_led(2, 2, 0, t));
        for (int t = 9; t <= 26; t++) led_q.push_back(exp_led(1, 2, 0, t - 8));
        @(posedge xclk);
        @(posedge xclk);
        #1;
        wrrd(2'd0, 8'd1, 8'd1);
        drain();
        rd(2'd0, 8'd1);
        drain();
        go_off();

        // Reset during BURST phase 0
        wr(2'd1, 8'd2);
        wr(2'd2, 8'd3);
        wr(2'd0, 8'd3);
        for (int t = 0; t < 3; t++) led_q.push_back(exp_led(3, 2, 3, t));
        repeat (10) led_q.push_back(led_t'(3'b000));
        @(posedge xclk);
        @(posedge xclk);
        #1;
        rst = 1'b1;
        @(posedge xclk);
        #1;
        rst = 1'b0;
        drain();
        read_resets();

`ifdef LED_PWM_EN
        begin
            int nr, ng;
            nr = 0;
            ng = 0;
            wr(2'd3, 8'd3);
            rd(2'd3, 8'd3);
            drain();
            wr(2'd1, 8'd10);
            wr(2'd0, 8'd2);
            repeat (2) @(posedge xclk);
            repeat (16) begin
                @(negedge xclk);
                nr += int'(led_r);
                ng += int'(led_g);
            end
            check("pwm_r_count", nr, 4);
            check("pwm_g_count", ng, 4);
        end
`else
        wr(2'd3, 8'd3);
        rd(2'd3, 8'd0);
        drain();
        run_scn(2, 1, 0);
`endif

        check("led_queue_empty", led_q.size(), 0);
        check("rd_queue_empty",  rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_sequencer.md
# led_sequencer

Register-programmable sequencer that drives the red and green board LEDs in place of the free-running flasher pattern. It sits between the I2C/Wishbone control register path and the LED output buffers. Software writes a mode, a half-period and a burst count. The block times the blink phases from `xclk`, applies mode changes only on phase boundaries, and optionally dims the lit LEDs with PWM.

## Interface
- `TICK_DIV`, 1000: `xclk` cycles per timebase tick; legal range 2..65535.
- `xclk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  single-cycle register write strobe.
- `cfg_re`  in  1  single-cycle register read strobe.
- `cfg_addr`  in  2  register select: 0 = MODE, 1 = HALF, 2 = BURST, 3 = DUTY.
- `cfg_wdata`  in  8  write data.
- `cfg_rdata`  out  8  read data, registered.
- `cfg_rvalid`  out  1  read data valid pulse.
- `led_r`  out  1  red LED drive, active-high, registered.
- `led_g`  out  1  green LED drive, active-high, registered.
- `done`  out  1  one-cycle pulse when a burst completes.

## Operation
- Reset values:
  - Outputs: `led_r`, `led_g`, `done`, `cfg_rvalid` = 0; `cfg_rdata` = 0x00.
  - Registers: MODE = 0, HALF = 50, BURST = 3, DUTY = 15.
  - Internal: prescaler, tick counter, phase and burst counter = 0; no pending mode.
- Prescaler counts 0..`TICK_DIV`-1 and wraps. `tick` is asserted in the cycle the count equals `TICK_DIV`-1.
- Phase timer counts ticks 0..HALF-1.
  - On the tick where the count equals HALF-1, the timer clears and `phase` toggles. This tick is the phase boundary.
  - HALF = 0 is treated as 1.
- Modes, taken from MODE[1:0]; MODE[7:2] is ignored on write and reads 0:
  - 0 OFF: both LEDs off; prescaler and phase held at 0.
  - 1 ALT: phase 0 drives red on, green off. Phase 1 drives red off, green on.
  - 2 SYNC: phase 0 drives both on. Phase 1 drives both off.
  - 3 BURST: same pattern as SYNC. The burst counter increments at each phase 1→0 boundary. When it reaches BURST:
    - the active mode becomes OFF and the MODE register reads 0;
    - `done` pulses for one cycle;
    - the burst counter clears.
  - BURST register = 0 gives no flashes. The block goes to OFF on the first 1→0 boundary with `done`, and both LEDs stay off throughout.
- Mode change rules:
  - Writing a nonzero MODE while active sets a pending mode. It is applied at the next phase boundary; `phase`, the phase timer and the burst counter then reset to 0.
  - Writing MODE from OFF applies it on the next cycle, starting in phase 0.
  - Writing 0 applies OFF on the next cycle and discards any pending mode.
  - Re-writing the currently active mode has no effect.
- A HALF write takes effect at the next phase boundary; the current phase finishes with the old value.
- Reads:
  - `cfg_rdata` and `cfg_rvalid` update one cycle after `cfg_re`.
  - MODE reads the pending value if one exists, otherwise the active mode.
  - `cfg_we` and `cfg_re` in the same cycle: the write wins, and the read returns the post-write value.
- Reset mid-sequence forces the reset values on the next edge. No `done` pulse is produced.

## Timing
- LED outputs change exactly one `xclk` after the boundary tick or mode apply.
- From OFF, a MODE write lights the first LED pattern 2 cycles after the `cfg_we` edge.
- One full blink cycle lasts 2·HALF·`TICK_DIV` `xclk` cycles.
- `done` is asserted in the same cycle that the LEDs go off at burst end.

## Configuration
- `LED_PWM_EN` defined:
  - A 4-bit free-running PWM counter runs on `xclk`.
  - An LED that the pattern selects as on is driven only while `pwm_cnt <= DUTY[3:0]`.
  - DUTY = 15 gives full on; DUTY = 0 gives a 1/16 duty.
  - DUTY writes apply immediately.
- `LED_PWM_EN` undefined: no PWM logic is built. DUTY writes are ignored, DUTY reads 0x00, and a selected-on LED is driven steadily.

## Test plan
- Reset, then read all four registers: MODE=0, HALF=50, BURST=3, DUTY=15; both LEDs 0.
- `TICK_DIV`=4, HALF=2, write MODE=1: red high for 8 cycles, then green high for 8 cycles, repeating; red and green never high together.
- MODE=2 running, write MODE=1 mid-phase: the SYNC pattern holds until the boundary, then ALT starts in phase 0; MODE readback returns 1 immediately.
- BURST=2, MODE=3, HALF=1, `TICK_DIV`=4: exactly 2 on-pulses of 4 cycles each; then `done` pulses once, the LEDs stay off, and MODE reads 0.
- Assert `rst` during BURST phase 0: the LEDs go to 0 on the next edge, no `done` is produced, and all registers return to their reset values.
- With `LED_PWM_EN` defined, DUTY=3 in SYNC phase 0: each LED is high 4 of every 16 cycles. Without the macro, DUTY reads 0 and the LEDs are steady high.
